// File: rtl/writeback_unit.sv
// Retirement/write-back stage: ALU results and load responses to the register file write port.
// WB_LOAD_ALIGN_EN enables byte/half lane extraction and sign/zero extension of load data.
module writeback_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rd,
  output logic [31:0] rdv,
  output logic        reg_wen,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic [31:0] retire_count
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state;
  logic [31:0] load_data;

  assign ex_ready = (state == IDLE);

`ifdef WB_LOAD_ALIGN_EN
  logic [2:0] ld_funct3;
  logic [1:0] ld_addr_lo;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = mem_rdata[8*ld_addr_lo +: 8];
    lane_h    = ld_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (ld_funct3)
      3'd0:    load_data = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_data = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_data = {24'd0, lane_b};
      3'd5:    load_data = {16'd0, lane_h};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_funct3  <= '0;
      ld_addr_lo <= '0;
    end else if (ex_valid && ex_ready && ex_is_load) begin
      ld_funct3  <= ex_funct3;
      ld_addr_lo <= ex_addr_lo;
    end
  end
`else
  logic unused_load_fields;
  assign unused_load_fields = ^{ex_funct3, ex_addr_lo};
  assign load_data = mem_rdata;
`endif

  // pend_rd doubles as the captured load destination while in WAIT_MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd           <= '0;
      rdv          <= '0;
      reg_wen      <= 1'b0;
      pend_valid   <= 1'b0;
      pend_rd      <= '0;
      retire_count <= '0;
    end else begin
      reg_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (ex_is_load) begin
              state      <= WAIT_MEM;
              pend_valid <= 1'b1;
              pend_rd    <= ex_rd;
            end else begin
              rd           <= ex_rd;
              rdv          <= ex_result;
              reg_wen      <= (ex_rd != '0);
              retire_count <= retire_count + 32'd1;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            rd           <= pend_rd;
            rdv          <= load_data;
            reg_wen      <= (pend_rd != '0);
            retire_count <= retire_count + 32'd1;
            state        <= IDLE;
            pend_valid   <= 1'b0;
            pend_rd      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected writes, a negedge monitor pops them.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rd;
  logic [31:0] rdv;
  logic        reg_wen;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic [31:0] retire_count;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];
  logic [31:0] exp_retire = 0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_is_load(ex_is_load),
    .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rd(rd), .rdv(rdv), .reg_wen(reg_wen),
    .pend_valid(pend_valid), .pend_rd(pend_rd), .retire_count(retire_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Chooses the expected load value for the active build
  function automatic logic [31:0] pick(input logic [31:0] aligned, input logic [31:0] raw);
`ifdef WB_LOAD_ALIGN_EN
    pick = aligned;
    if (raw == 32'hx) pick = 32'hx;
`else
    pick = raw;
    if (aligned == 32'hx) pick = 32'hx;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && reg_wen === 1'b1) begin
      logic [36:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: rd=%0d rdv=0x%08h, no write expected", rd, rdv);
      end else begin
        e = exp_q.pop_front();
        if ({rd, rdv} !== e) begin
          errors++;
          $display("FAIL write: got rd=%0d rdv=0x%08h expected rd=%0d rdv=0x%08h",
                   rd, rdv, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic send_alu(input logic [4:0] r, input logic [31:0] res);
    chk("alu_ex_ready", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = r; ex_result = res;
    if (r != 0) exp_q.push_back({r, res});
    exp_retire++;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic send_load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] data, input int delay, input logic [31:0] exp);
    chk("ld_ex_ready", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = r; ex_funct3 = f3; ex_addr_lo = lo;
    ex_result = 32'h5555_AAAA;
    if (r != 0) exp_q.push_back({r, exp});
    exp_retire++;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    for (int i = 1; i < delay; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_pend_valid", {31'd0, pend_valid}, 32'd1);
    chk("wait_pend_rd", {27'd0, pend_rd}, {27'd0, r});
    chk("wait_ex_ready", {31'd0, ex_ready}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = data;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("done_pend_valid", {31'd0, pend_valid}, 32'd0);
    chk("done_pend_rd", {27'd0, pend_rd}, 32'd0);
    chk("done_ex_ready", {31'd0, ex_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_result = '0; ex_is_load = 1'b0;
    ex_funct3 = '0; ex_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_rdv", rdv, 32'd0);
    chk("rst_reg_wen", {31'd0, reg_wen}, 32'd0);
    chk("rst_pend_valid", {31'd0, pend_valid}, 32'd0);
    chk("rst_pend_rd", {27'd0, pend_rd}, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_alu(5'd5, 32'hDEADBEEF);
    chk("retire_after_alu", retire_count, 32'd1);

    send_alu(5'd1, 32'h1111_0001);
    send_alu(5'd2, 32'h2222_0002);
    send_alu(5'd3, 32'h3333_0003);
    chk("retire_b2b", retire_count, exp_retire);

    send_alu(5'd0, 32'hFFFF_FFFF);
    chk("retire_alu_x0", retire_count, exp_retire);

    send_load(5'd7, 3'd0, 2'd3, 32'h80FF_FF00, 3, pick(32'hFFFF_FF80, 32'h80FF_FF00));
    send_load(5'd8, 3'd5, 2'd2, 32'hABCD_1234, 1, pick(32'h0000_ABCD, 32'hABCD_1234));
    send_load(5'd9, 3'd1, 2'd0, 32'h0000_8001, 2, pick(32'hFFFF_8001, 32'h0000_8001));
    send_load(5'd10, 3'd4, 2'd1, 32'h1234_F678, 1, pick(32'h0000_00F6, 32'h1234_F678));
    send_load(5'd11, 3'd1, 2'd3, 32'h7FFF_0000, 1, pick(32'h0000_7FFF, 32'h7FFF_0000));
    send_load(5'd12, 3'd2, 2'd3, 32'hCAFE_BABE, 1, 32'hCAFE_BABE);
    send_load(5'd13, 3'd7, 2'd1, 32'h8765_4321, 2, 32'h8765_4321);
    send_load(5'd0, 3'd2, 2'd0, 32'h1234_5678, 2, 32'h0);
    chk("retire_after_loads", retire_count, exp_retire);

    // Load handshake followed directly by an ALU op: write lands two cycles after response
    send_load(5'd14, 3'd0, 2'd0, 32'h0000_007F, 1, pick(32'h0000_007F, 32'h0000_007F));
    send_alu(5'd15, 32'h0BAD_F00D);
    chk("retire_mixed", retire_count, exp_retire);

    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("idle_rvalid_retire", retire_count, exp_retire);
    chk("idle_rvalid_ready", {31'd0, ex_ready}, 32'd1);

    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd20; ex_funct3 = 3'd2;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("pre_rst_pend_valid", {31'd0, pend_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("async_rst_pend", {31'd0, pend_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_retire = 0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_retire", retire_count, 32'd0);
    chk("post_rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("post_rst_pend_rd", {27'd0, pend_rd}, 32'd0);

    send_alu(5'd31, 32'h0000_0042);
    @(posedge clk); #1;
    chk("retire_restart", retire_count, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Retirement stage that produces the write port of the 32x32 register file (rd, rdv, reg_wen) from completed instructions. Accepts ALU results and load requests from execute over a valid/ready handshake. ALU results are written back directly. Loads wait for the data-memory response, then the unit extracts and sign/zero-extends the data and writes it back. The unit also exposes the pending load destination to the hazard logic and keeps a retired-instruction counter.

## Interface
Parameters:
- none; widths are fixed for RV32 (XLEN 32, 5-bit register index).

Ports:
- clk  in  1  Sole clock; all state updates on posedge.
- rst_n  in  1  Reset. Asynchronous assert, active-low.
- ex_valid  in  1  Execute presents a completed instruction.
- ex_ready  out  1  Unit accepts this cycle; transfer when ex_valid && ex_ready.
- ex_rd  in  5  Destination register index.
- ex_result  in  32  ALU result, used when ex_is_load=0.
- ex_is_load  in  1  Instruction is a load.
- ex_funct3  in  3  Load width/sign: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- ex_addr_lo  in  2  Low bits of the load byte address.
- mem_rvalid  in  1  Data-memory response valid, single-cycle pulse.
- mem_rdata  in  32  Aligned 32-bit word containing the load data.
- rd  out  5  Register file write index.
- rdv  out  32  Register file write data.
- reg_wen  out  1  Register file write enable, one cycle per write.
- pend_valid  out  1  A load is outstanding.
- pend_rd  out  5  Destination of the outstanding load; 0 when none.
- retire_count  out  32  Instructions retired since reset.

## Operation
- State machine with two states: IDLE and WAIT_MEM. Reset state is IDLE.
- ex_ready = (state == IDLE). This is a combinational decode of state only.
- IDLE, accept with ex_is_load=0:
  - Next cycle: rd=ex_rd, rdv=ex_result, reg_wen=(ex_rd!=0).
  - retire_count increments.
  - State stays IDLE.
- IDLE, accept with ex_is_load=1:
  - Capture ex_rd, ex_funct3 and ex_addr_lo; go to WAIT_MEM.
  - pend_valid=1 and pend_rd=ex_rd from the next cycle.
- WAIT_MEM, mem_rvalid=1:
  - Extract and extend the data (see Configuration).
  - Next cycle: rd, rdv and reg_wen=(captured rd!=0).
  - retire_count increments; state returns to IDLE; pend_valid=0, pend_rd=0.
- WAIT_MEM, mem_rvalid=0: hold. There is no timeout.
- Extraction:
  - Byte: lane ex_addr_lo.
  - Half: ex_addr_lo[1] selects the upper half; ex_addr_lo[0] is ignored.
  - Word: ex_addr_lo is ignored.
  - funct3 values 3, 6 and 7 are treated as LW.
- Loads to x0 still wait for the response and still count as retired, but never assert reg_wen.
- mem_rvalid in IDLE is ignored: no write, no count change.
- retire_count wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: rd=0, rdv=0, reg_wen=0, pend_valid=0, pend_rd=0, retire_count=0, state IDLE, so ex_ready=1.
- rd, rdv, reg_wen and retire_count are registered. reg_wen is high for exactly one cycle per write and is 0 in every other cycle.
- ALU latency: handshake in cycle N, write visible in cycle N+1. Throughput is one per cycle.
- Load latency: response in cycle M, write in cycle M+1. ex_ready returns to 1 in cycle M+1, so the next instruction's write lands at M+2 or later.
- A response in the same cycle as the load handshake falls in IDLE and is ignored. Memory must respond at N+1 or later.
- rst_n asserted during WAIT_MEM: return to IDLE immediately and drop the pending load. A later mem_rvalid is ignored.
- The register file's same-cycle write bypass consumes rd/rdv/reg_wen directly. No extra forwarding is done here.

## Configuration
- WB_LOAD_ALIGN_EN defined: full LB/LH/LBU/LHU lane extraction and sign/zero extension as described in Operation.
- Undefined:
  - Every load writes mem_rdata unmodified; ex_funct3 and ex_addr_lo are ignored.
  - Handshake and timing are unchanged.

## Test plan
- Reset then ALU op rd=5, result 0xDEADBEEF: one cycle later reg_wen=1, rd=5, rdv=0xDEADBEEF. retire_count=1.
- Back-to-back ALU ops rd=1,2,3: reg_wen high for three consecutive cycles with matching rd/rdv. ex_ready stays 1.
- LB rd=7, addr_lo=3, response 0x80FF_FF00 after 3 cycles:
  - pend_valid=1, pend_rd=7 while waiting; ex_ready=0.
  - Then rdv=0xFFFFFF80.
  - With the macro undefined, rdv=0x80FFFF00 instead.
- LHU addr_lo=2, data 0xABCD1234 → rdv=0x0000ABCD. LH addr_lo=0, data 0x00008001 → rdv=0xFFFF8001.
- Load to rd=0: response arrives, no reg_wen, retire_count increments.
- Assert rst_n low during WAIT_MEM, release, then pulse mem_rvalid: no write, retire_count=0, ex_ready=1.
